l2_mem_port_arbiter: RTL and testbench

Arbitrates the instruction-cache miss port, data-cache load-miss port and data-cache store port onto the single shared L2 memory port of the testbench memory hierarchy. It keeps exactly one transaction outstanding and sequences each one from grant through completion. It routes the line or store-complete response back to the requester that owns the transaction, and flags transactions that never complete. It sits between the L1 caches and the L2 model inside the memory hierarchy wrapper.

---
 rtl/l2_mem_port_arbiter_pkg.sv | 20 ++
 rtl/l2_mem_port_arbiter_rr_arb3.sv | 25 ++
 rtl/l2_mem_port_arbiter.sv | 216 +++++++++++++++++++++
 tb/tb_l2_mem_port_arbiter.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/l2_mem_port_arbiter_pkg.sv
// Shared types and defaults for the L2 memory port arbiter.
// Owner encoding doubles as the round-robin pointer value.
package l2_mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    OWN_IC = 2'd0,
    OWN_LD = 2'd1,
    OWN_ST = 2'd2
  } owner_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    RD_WAIT = 2'd2,
    WR_WAIT = 2'd3
  } state_t;

  localparam int DEFAULT_TIMEOUT_CYCLES = 1023;

endpackage

// File: rtl/l2_mem_port_arbiter_rr_arb3.sv
// Three-way round-robin picker: the first set request at or after ptr,
// wrapping 2 -> 0, gets the one-hot grant.
module rr_arb3 (
  input  logic [2:0] req,
  input  logic [1:0] ptr,
  output logic [2:0] grant
);

  logic       found;
  logic [1:0] idx;

  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = 2'd0;
    for (int k = 0; k < 3; k++) begin
      idx = 2'((int'(ptr) + k) % 3);
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/l2_mem_port_arbiter.sv
// Shares one L2 port between I-cache misses, D-cache load misses and stores,
// keeping a single transaction in flight and routing its completion back.
module l2_mem_port_arbiter
  import l2_mem_port_arbiter_pkg::*;
#(
  parameter int BLOCK_ADDR_W   = 26,
  parameter int LINE_BITS      = 256,
  parameter int DATA_W         = 64,
  parameter int BE_W           = DATA_W / 8,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    ic_req_valid_i,
  input  logic [BLOCK_ADDR_W-1:0] ic_req_addr_i,
  output logic                    ic_req_ready_o,
  output logic                    ic_resp_valid_o,
  output logic [LINE_BITS-1:0]    ic_resp_data_o,
  input  logic                    dc_ld_valid_i,
  input  logic [BLOCK_ADDR_W-1:0] dc_ld_addr_i,
  output logic                    dc_ld_ready_o,
  output logic                    dc_ld_resp_valid_o,
  output logic [LINE_BITS-1:0]    dc_ld_resp_data_o,
  input  logic                    dc_st_valid_i,
  input  logic [BLOCK_ADDR_W-1:0] dc_st_addr_i,
  input  logic [DATA_W-1:0]       dc_st_data_i,
  input  logic [BE_W-1:0]         dc_st_byteen_i,
  output logic                    dc_st_ready_o,
  output logic                    dc_st_done_o,
  output logic                    mem_re_o,
  output logic [BLOCK_ADDR_W-1:0] mem_rd_addr_o,
  input  logic                    mem_rd_valid_i,
  input  logic [LINE_BITS-1:0]    mem_rd_data_i,
  output logic                    mem_we_o,
  output logic [BLOCK_ADDR_W-1:0] mem_wr_addr_o,
  output logic [DATA_W-1:0]       mem_wr_data_o,
  output logic [BE_W-1:0]         mem_wr_byteen_o,
  input  logic                    mem_wr_done_i,
  output logic                    busy_o,
  output logic                    timeout_o,
  output logic                    err_o
);

  localparam logic [9:0] TIMEOUT_LAST = 10'(TIMEOUT_CYCLES - 1);

  state_t state, nextState;
  owner_t rrPtr, owner, winner, nextPtr;

  logic [2:0]              reqVec;
  logic [2:0]              grant;
  logic                    accept;
  logic                    waiting;
  logic                    rdDone;
  logic                    wrDone;
  logic                    waitExpired;
  logic [BLOCK_ADDR_W-1:0] winAddr;
  logic [BLOCK_ADDR_W-1:0] addrReg;
  logic [DATA_W-1:0]       dataReg;
  logic [BE_W-1:0]         beReg;
  logic [9:0]              waitCnt;
  logic                    icRespValid;
  logic                    ldRespValid;
  logic                    stDone;
  logic                    errPulse;
  logic                    timeoutReg;
  logic [LINE_BITS-1:0]    icRespData;
  logic [LINE_BITS-1:0]    ldRespData;

  assign reqVec = {dc_st_valid_i, dc_ld_valid_i, ic_req_valid_i};

  rr_arb3 u_arb (
    .req  (reqVec),
    .ptr  (rrPtr),
    .grant(grant)
  );

  assign ic_req_ready_o = (state == IDLE) && grant[0];
  assign dc_ld_ready_o  = (state == IDLE) && grant[1];
  assign dc_st_ready_o  = (state == IDLE) && grant[2];
  assign accept         = (state == IDLE) && (grant != 3'b000);

  assign waiting     = (state == RD_WAIT) || (state == WR_WAIT);
  assign rdDone      = (state == RD_WAIT) && mem_rd_valid_i;
  assign wrDone      = (state == WR_WAIT) && mem_wr_done_i;
  assign waitExpired = waiting && !rdDone && !wrDone && (waitCnt == TIMEOUT_LAST);

  always_comb begin
    winner  = OWN_IC;
    winAddr = ic_req_addr_i;
    if (grant[1]) begin
      winner  = OWN_LD;
      winAddr = dc_ld_addr_i;
    end
    if (grant[2]) begin
      winner  = OWN_ST;
      winAddr = dc_st_addr_i;
    end
    case (winner)
      OWN_IC:  nextPtr = OWN_LD;
      OWN_LD:  nextPtr = OWN_ST;
      default: nextPtr = OWN_IC;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= nextState;
  end

  always_comb begin
    nextState = state;
    mem_re_o  = 1'b0;
    mem_we_o  = 1'b0;
    busy_o    = (state != IDLE);
    case (state)
      IDLE: begin
        if (accept) nextState = ISSUE;
      end
      ISSUE: begin
        mem_re_o  = (owner != OWN_ST);
        mem_we_o  = (owner == OWN_ST);
        nextState = (owner == OWN_ST) ? WR_WAIT : RD_WAIT;
      end
      RD_WAIT: begin
        if (rdDone || waitExpired) nextState = IDLE;
      end
      WR_WAIT: begin
        if (wrDone || waitExpired) nextState = IDLE;
      end
      default: nextState = IDLE;
    endcase
  end

  // Store data and byte enables are only meaningful for a store winner.
  always_ff @(posedge clk) begin
    if (reset) begin
      owner   <= OWN_IC;
      rrPtr   <= OWN_IC;
      addrReg <= '0;
      dataReg <= '0;
      beReg   <= '0;
    end else if (accept) begin
      owner   <= winner;
      rrPtr   <= nextPtr;
      addrReg <= winAddr;
      dataReg <= (winner == OWN_ST) ? dc_st_data_i : '0;
      beReg   <= (winner == OWN_ST) ? dc_st_byteen_i : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      waitCnt <= '0;
    end else if (state == ISSUE) begin
      waitCnt <= '0;
    end else if (waiting && !rdDone && !wrDone && (waitCnt != 10'h3FF)) begin
      waitCnt <= waitCnt + 10'd1;
    end
  end

  // A timed-out transaction still answers its owner, with zero data and err.
  always_ff @(posedge clk) begin
    if (reset) begin
      icRespValid <= 1'b0;
      ldRespValid <= 1'b0;
      stDone      <= 1'b0;
      errPulse    <= 1'b0;
      timeoutReg  <= 1'b0;
      icRespData  <= '0;
      ldRespData  <= '0;
    end else begin
      icRespValid <= 1'b0;
      ldRespValid <= 1'b0;
      stDone      <= 1'b0;
      errPulse    <= 1'b0;
      if (rdDone) begin
        if (owner == OWN_IC) begin
          icRespValid <= 1'b1;
          icRespData  <= mem_rd_data_i;
        end else begin
          ldRespValid <= 1'b1;
          ldRespData  <= mem_rd_data_i;
        end
      end
      if (wrDone) stDone <= 1'b1;
      if (waitExpired) begin
        timeoutReg <= 1'b1;
        errPulse   <= 1'b1;
        case (owner)
          OWN_IC: begin
            icRespValid <= 1'b1;
            icRespData  <= '0;
          end
          OWN_LD: begin
            ldRespValid <= 1'b1;
            ldRespData  <= '0;
          end
          default: stDone <= 1'b1;
        endcase
      end
    end
  end

  assign mem_rd_addr_o      = addrReg;
  assign mem_wr_addr_o      = addrReg;
  assign mem_wr_data_o      = dataReg;
  assign mem_wr_byteen_o    = beReg;
  assign ic_resp_valid_o    = icRespValid;
  assign ic_resp_data_o     = icRespData;
  assign dc_ld_resp_valid_o = ldRespValid;
  assign dc_ld_resp_data_o  = ldRespData;
  assign dc_st_done_o       = stDone;
  assign err_o              = errPulse;
  assign timeout_o          = timeoutReg;

endmodule

// File: tb/tb_l2_mem_port_arbiter.sv
// Bench for l2_mem_port_arbiter: a table of transactions plus hand-written
// corner sequences, with responses matched against a scoreboard queue.
module tb_l2_mem_port_arbiter;

  typedef struct {
    logic [2:0]   reqMask;
    logic [25:0]  icAddr;
    logic [25:0]  ldAddr;
    logic [25:0]  stAddr;
    logic [63:0]  stData;
    logic [7:0]   stBe;
    logic [2:0]   expReady;
    logic [25:0]  expAddr;
    int           delay;
    logic [255:0] rdData;
  } vec_t;

  typedef struct {
    logic [2:0]   mask;
    logic [255:0] data;
    logic         err;
  } expResp_t;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         icValid = 1'b0, ldValid = 1'b0, stValid = 1'b0;
  logic [25:0]  icAddr = '0, ldAddr = '0, stAddr = '0;
  logic [63:0]  stData = '0;
  logic [7:0]   stBe = '0;
  logic         memRdValid = 1'b0, memWrDone = 1'b0;
  logic [255:0] memRdData = '0;

  logic         icReady, icRespValid, ldReady, ldRespValid, stReady, stDone;
  logic [255:0] icRespData, ldRespData;
  logic         memRe, memWe, busy, timeoutFlag, errFlag;
  logic [25:0]  memRdAddr, memWrAddr;
  logic [63:0]  memWrData;
  logic [7:0]   memWrBe;

  int           vecCount = 0;
  int           missCount = 0;
  expResp_t     sbQ[$];
  expResp_t     monExp;
  logic [2:0]   monMask;
  vec_t         vecs[9];
  int           waitCycles;

  l2_mem_port_arbiter #(.TIMEOUT_CYCLES(8)) dut (
    .clk               (clk),
    .reset             (reset),
    .ic_req_valid_i    (icValid),
    .ic_req_addr_i     (icAddr),
    .ic_req_ready_o    (icReady),
    .ic_resp_valid_o   (icRespValid),
    .ic_resp_data_o    (icRespData),
    .dc_ld_valid_i     (ldValid),
    .dc_ld_addr_i      (ldAddr),
    .dc_ld_ready_o     (ldReady),
    .dc_ld_resp_valid_o(ldRespValid),
    .dc_ld_resp_data_o (ldRespData),
    .dc_st_valid_i     (stValid),
    .dc_st_addr_i      (stAddr),
    .dc_st_data_i      (stData),
    .dc_st_byteen_i    (stBe),
    .dc_st_ready_o     (stReady),
    .dc_st_done_o      (stDone),
    .mem_re_o          (memRe),
    .mem_rd_addr_o     (memRdAddr),
    .mem_rd_valid_i    (memRdValid),
    .mem_rd_data_i     (memRdData),
    .mem_we_o          (memWe),
    .mem_wr_addr_o     (memWrAddr),
    .mem_wr_data_o     (memWrData),
    .mem_wr_byteen_o   (memWrBe),
    .mem_wr_done_i     (memWrDone),
    .busy_o            (busy),
    .timeout_o         (timeoutFlag),
    .err_o             (errFlag)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no finish, expected finish within 200000 time units");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [255:0] act, input logic [255:0] exp);
    vecCount++;
    if (act !== exp) begin
      missCount++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mkVec(input logic [2:0] mask, input logic [25:0] ia, input logic [25:0] la,
                                 input logic [25:0] sa, input logic [63:0] sd, input logic [7:0] sb,
                                 input logic [2:0] er, input logic [25:0] ea, input int dly,
                                 input logic [255:0] rd);
    vec_t v;
    v.reqMask = mask; v.icAddr = ia; v.ldAddr = la; v.stAddr = sa; v.stData = sd;
    v.stBe = sb; v.expReady = er; v.expAddr = ea; v.delay = dly; v.rdData = rd;
    return v;
  endfunction

  task automatic applyStimulus(input vec_t v);
    icValid = v.reqMask[0];
    ldValid = v.reqMask[1];
    stValid = v.reqMask[2];
    icAddr  = v.icAddr;
    ldAddr  = v.ldAddr;
    stAddr  = v.stAddr;
    stData  = v.stData;
    stBe    = v.stBe;
  endtask

  // Response pulses are matched in order against what the stimulus expects.
  always @(negedge clk) begin
    monMask = {stDone, ldRespValid, icRespValid};
    if (monMask != 3'b000) begin
      if (sbQ.size() == 0) begin
        checkOutput("unexpectedResp", {253'd0, monMask}, 256'd0);
      end else begin
        monExp = sbQ.pop_front();
        checkOutput("respOwner", {253'd0, monMask}, {253'd0, monExp.mask});
        checkOutput("respErr", {255'd0, errFlag}, {255'd0, monExp.err});
        if (monExp.mask != 3'b100)
          checkOutput("respData", monMask[0] ? icRespData : ldRespData, monExp.data);
      end
    end else if (errFlag) begin
      checkOutput("strayErr", {255'd0, errFlag}, 256'd0);
    end
  end

  task automatic runTxn(input vec_t v);
    expResp_t e;
    applyStimulus(v);
    #1;
    checkOutput("ready", {253'd0, stReady, ldReady, icReady}, {253'd0, v.expReady});
    checkOutput("busyIdle", {255'd0, busy}, 256'd0);
    stepCycle();
    icValid = 1'b0; ldValid = 1'b0; stValid = 1'b0;
    checkOutput("memRe", {255'd0, memRe}, {255'd0, ~v.expReady[2]});
    checkOutput("memWe", {255'd0, memWe}, {255'd0, v.expReady[2]});
    if (v.expReady[2]) begin
      checkOutput("memWrAddr", {230'd0, memWrAddr}, {230'd0, v.expAddr});
      checkOutput("memWrBe", {248'd0, memWrBe}, {248'd0, v.stBe});
      checkOutput("memWrData", {192'd0, memWrData}, {192'd0, v.stData});
    end else begin
      checkOutput("memRdAddr", {230'd0, memRdAddr}, {230'd0, v.expAddr});
    end
    stepCycle();
    repeat (v.delay) stepCycle();
    e.mask = v.expReady;
    e.data = v.rdData;
    e.err  = 1'b0;
    if (v.expReady[2]) memWrDone = 1'b1;
    else begin
      memRdValid = 1'b1;
      memRdData  = v.rdData;
    end
    sbQ.push_back(e);
    stepCycle();
    memWrDone  = 1'b0;
    memRdValid = 1'b0;
    memRdData  = {8{32'hFFFF_0000}};
    checkOutput("idleAfterResp", {255'd0, busy}, 256'd0);
  endtask

  initial begin
    expResp_t e;
    vecs[0] = mkVec(3'b111, 26'h100, 26'h200, 26'h300, 64'h1122_3344_5566_7788, 8'hFF, 3'b001, 26'h100, 0, {8{32'h1111_0001}});
    vecs[1] = mkVec(3'b111, 26'h100, 26'h200, 26'h300, 64'h1122_3344_5566_7788, 8'hFF, 3'b010, 26'h200, 1, {8{32'hDEAD_BEEF}});
    vecs[2] = mkVec(3'b111, 26'h100, 26'h200, 26'h300, 64'h1122_3344_5566_7788, 8'hFF, 3'b100, 26'h300, 0, '0);
    vecs[3] = mkVec(3'b001, 26'h104, 26'h0,   26'h0,   64'h0,                   8'h00, 3'b001, 26'h104, 3, {32{8'hA5}});
    vecs[4] = mkVec(3'b100, 26'h0,   26'h0,   26'h3F0, 64'hCAFE_F00D_0BAD_BEEF, 8'h0F, 3'b100, 26'h3F0, 2, '0);
    vecs[5] = mkVec(3'b110, 26'h0,   26'h2AA, 26'h3A0, 64'h0000_0000_0000_00AB, 8'h01, 3'b010, 26'h2AA, 0, {4{64'h0123_4567_89AB_CDEF}});
    vecs[6] = mkVec(3'b101, 26'h1A0, 26'h0,   26'h3A0, 64'h0000_0000_0000_00AB, 8'h81, 3'b100, 26'h3A0, 4, '0);
    vecs[7] = mkVec(3'b011, 26'h1A0, 26'h2B0, 26'h0,   64'h0,                   8'h00, 3'b001, 26'h1A0, 5, {16{16'h5A3C}});
    vecs[8] = mkVec(3'b110, 26'h0,   26'h2B0, 26'h3B0, 64'h7,                   8'h80, 3'b010, 26'h2B0, 2, {8{32'h8765_4321}});

    $display("[TB] starting");
    repeat (3) stepCycle();
    reset = 1'b0;
    checkOutput("resetBusy", {255'd0, busy}, 256'd0);
    checkOutput("resetTimeout", {255'd0, timeoutFlag}, 256'd0);
    checkOutput("resetStrobes", {252'd0, memRe, memWe, errFlag, icRespValid}, 256'd0);
    checkOutput("resetAddr", {230'd0, memRdAddr}, 256'd0);

    for (int i = 0; i < 9; i++) runTxn(vecs[i]);

    // Stray completions while idle must not produce anything.
    memRdValid = 1'b1; memRdData = {32{8'h3C}}; memWrDone = 1'b1;
    stepCycle();
    memRdValid = 1'b0; memWrDone = 1'b0;
    checkOutput("strayIdleBusy", {255'd0, busy}, 256'd0);
    stepCycle();
    checkOutput("strayIdleBusy2", {255'd0, busy}, 256'd0);

    // Write completion during a read wait is ignored.
    icValid = 1'b1; icAddr = 26'h1C0;
    #1;
    checkOutput("wrongKindReady", {253'd0, stReady, ldReady, icReady}, 256'd1);
    stepCycle();
    icValid = 1'b0;
    stepCycle();
    memWrDone = 1'b1;
    stepCycle();
    memWrDone = 1'b0;
    checkOutput("wrongKindBusy", {255'd0, busy}, 256'd1);
    memRdValid = 1'b1; memRdData = {8{32'h0F0F_1234}};
    e.mask = 3'b001; e.data = {8{32'h0F0F_1234}}; e.err = 1'b0;
    sbQ.push_back(e);
    stepCycle();
    memRdValid = 1'b0;
    checkOutput("wrongKindDone", {255'd0, busy}, 256'd0);

    // Load with no completion: abandoned in the 8th wait cycle.
    ldValid = 1'b1; ldAddr = 26'h2F0;
    #1;
    checkOutput("toReady", {253'd0, stReady, ldReady, icReady}, 256'd2);
    stepCycle();
    ldValid = 1'b0;
    checkOutput("toIssue", {255'd0, memRe}, 256'd1);
    checkOutput("toNotYet", {255'd0, timeoutFlag}, 256'd0);
    e.mask = 3'b010; e.data = '0; e.err = 1'b1;
    sbQ.push_back(e);
    waitCycles = 0;
    while (busy && waitCycles < 30) begin
      stepCycle();
      waitCycles++;
    end
    checkOutput("toCycles", 256'(waitCycles), 256'd9);
    checkOutput("toSticky", {255'd0, timeoutFlag}, 256'd1);

    runTxn(mkVec(3'b100, 26'h0, 26'h0, 26'h3C4, 64'h55AA, 8'h3C, 3'b100, 26'h3C4, 1, '0));
    checkOutput("toStillSticky", {255'd0, timeoutFlag}, 256'd1);

    // Reset in the middle of a read abandons it silently.
    icValid = 1'b1; icAddr = 26'h1E0;
    stepCycle();
    icValid = 1'b0;
    stepCycle();
    checkOutput("preResetBusy", {255'd0, busy}, 256'd1);
    reset = 1'b1;
    stepCycle();
    reset = 1'b0;
    checkOutput("midResetBusy", {255'd0, busy}, 256'd0);
    checkOutput("midResetTimeout", {255'd0, timeoutFlag}, 256'd0);
    checkOutput("midResetStrobes", {252'd0, memRe, memWe, errFlag, stDone}, 256'd0);
    checkOutput("midResetAddr", {230'd0, memRdAddr}, 256'd0);
    checkOutput("midResetBe", {248'd0, memWrBe}, 256'd0);
    checkOutput("midResetIcData", icRespData, 256'd0);
    checkOutput("midResetLdData", ldRespData, 256'd0);
    memRdValid = 1'b1; memRdData = {8{32'h7777_7777}};
    stepCycle();
    memRdValid = 1'b0;
    repeat (4) stepCycle();
    checkOutput("postResetIdle", {255'd0, busy}, 256'd0);
    checkOutput("scoreboardDrained", 256'(sbQ.size()), 256'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
